pipelined_shifter: RTL and testbench
====================================

PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (power of two, 8..64).
REQ-002 SHALL have derived localparam SHAMT_W, equal to log2(WIDTH), meaning the number of shift-amount bits and the number of pipeline stages.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: dataA/dataB/op are presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an input this cycle.
REQ-007 SHALL have port dataA, input, WIDTH bits: value to shift.
REQ-008 SHALL have port dataB, input, WIDTH bits: shift amount; only bits [SHAMT_W-1:0] are used and upper bits are ignored.
REQ-009 SHALL have port op, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 SHALL have port out_valid, output, 1 bit: dataOut holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port dataOut, output, WIDTH bits: the shifted result.

Function
REQ-013 SHALL transfer an input when in_valid && in_ready, and deliver an output when out_valid && out_ready.
REQ-014 SHALL implement SHAMT_W register stages; stage k shifts by 2^k or by 0, selected by shamt bit k.
REQ-015 SHALL have latency SHAMT_W cycles from input accept to out_valid, given no stall.
REQ-016 SHALL sustain throughput of one operation per cycle while out_ready=1.
REQ-017 SHALL, per stage, carry the valid bit, data, op and remaining shamt bits.
REQ-018 SHALL advance a stage when its successor is empty or advancing; in_ready = !stage0_valid || stage0_advances (bubbles collapse, no combinational path from in_valid to in_ready).
REQ-019 SHALL hold dataOut and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL fill zeros for SLL/SRL, replicate the MSB of the stage input for SRA, and wrap bits for ROR.
REQ-021 SHALL pass dataA unchanged through all stages when the shift amount is 0, for every op.
REQ-022 SHALL, when an accept and an output handshake occur in the same cycle with the pipe full, complete both without data loss.
REQ-023 SHALL keep every stage at its current content when stalled; no op is dropped or duplicated.

Reset
REQ-024 SHALL clear all stage valid bits on rst=1 at a clock edge; out_valid=0 and dataOut=0 the following cycle.
REQ-025 SHALL drop in-flight operations on rst mid-operation; in_ready=1 in the first cycle after rst deasserts.
REQ-026 SHALL clear the stage data registers to 0 on reset.

Configuration
REQ-027 SHALL, with SHIFTER_ROTATE_EN defined, implement op=11 as ROR.
REQ-028 SHALL, without SHIFTER_ROTATE_EN, decode op=11 as SRL and omit the wrap-around logic.

Structure
REQ-029 SHALL take the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROR) from a shared header, shifter_defs.vh, used by the ALU and the bench.
REQ-030 SHALL use one sub-module, shift_stage (parameters WIDTH, DIST), instantiated SHAMT_W times via generate; it contains one mux level plus its registers.

Verification
REQ-031 SHALL cover: WIDTH=32, SLL dataA=0x00000001, dataB=31 -> dataOut=0x80000000, out_valid exactly 5 cycles after accept.
REQ-032 SHALL cover: SRA dataA=0x80000000, dataB=4 -> 0xF8000000; SRL of the same -> 0x08000000.
REQ-033 SHALL cover: ROR dataA=0x00000001, dataB=0x21 (upper bits ignored, amount 1) -> 0x80000000 with the macro defined; without it -> 0x00000000.
REQ-034 SHALL cover: 8 back-to-back inputs with out_ready held 0 for 10 cycles -> in_ready=0 once all 5 stages are full, then 8 results in order after release with none lost.
REQ-035 SHALL cover: rst pulsed with 3 ops in flight -> out_valid=0 and dataOut=0 the next cycle, with no stale results afterwards.
REQ-036 SHALL cover: WIDTH=8 random sweep of op/dataA/dataB against a reference model -> zero mismatches, latency 3.

Source files
------------

// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings used by the datapath and the bench.
// Rotate support is selected by the SHIFTER_ROTATE_EN macro inside the stage.
package pipelined_shifter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shiftOp_e;

endpackage

// File: rtl/pipelined_shifter_stage.sv
// One barrel-shifter level: shifts by DIST or 0 (chosen by the matching shamt bit) and registers the result.
// Define SHIFTER_ROTATE_EN to build op=11 as rotate-right; otherwise op=11 behaves as SRL.
module shift_stage
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               loadEn,
  input  logic               prevValid,
  input  logic [WIDTH-1:0]   prevData,
  input  logic [OP_W-1:0]    prevOp,
  input  logic [SHAMT_W-1:0] prevShamt,
  output logic               stageValid,
  output logic [WIDTH-1:0]   stageData,
  output logic [OP_W-1:0]    stageOp,
  output logic [SHAMT_W-1:0] stageShamt
);

  localparam int SEL = $clog2(DIST);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = prevData;
    if (prevShamt[SEL]) begin
      case (prevOp)
        OP_SLL:  shifted = prevData << DIST;
        OP_SRA:  shifted = $signed(prevData) >>> DIST;
`ifdef SHIFTER_ROTATE_EN
        OP_SRL:  shifted = prevData >> DIST;
        OP_ROR:  shifted = {prevData[DIST-1:0], prevData[WIDTH-1:DIST]};
`else
        // Without rotate support op=11 decodes as a logical right shift.
        OP_SRL, OP_ROR: shifted = prevData >> DIST;
`endif
        default: shifted = prevData;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stageValid <= 1'b0;
      stageData  <= '0;
      stageOp    <= OP_SLL;
      stageShamt <= '0;
    end else if (loadEn) begin
      stageValid <= prevValid;
      stageData  <= shifted;
      stageOp    <= prevOp;
      stageShamt <= prevShamt;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) register stages with valid/ready flow control and bubble collapsing.
// Define SHIFTER_ROTATE_EN to enable ROR for op=11 (default build treats op=11 as SRL).
module pipelined_shifter
  import pipelined_shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // Index 0 is the input port; index k+1 is the register output of stage k.
  logic               stValid [SHAMT_W+1];
  logic [WIDTH-1:0]   stData  [SHAMT_W+1];
  logic [OP_W-1:0]    stOp    [SHAMT_W+1];
  logic [SHAMT_W-1:0] stShamt [SHAMT_W+1];

  logic [SHAMT_W-1:0] fullVec;
  logic [SHAMT_W-1:0] loadEn;

  assign stValid[0] = in_valid;
  assign stData[0]  = dataA;
  assign stOp[0]    = op;
  assign stShamt[0] = dataB[SHAMT_W-1:0];

  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : gStage
    shift_stage #(
      .WIDTH(WIDTH),
      .DIST (1 << gi)
    ) uStage (
      .clk       (clk),
      .rst       (rst),
      .loadEn    (loadEn[gi]),
      .prevValid (stValid[gi]),
      .prevData  (stData[gi]),
      .prevOp    (stOp[gi]),
      .prevShamt (stShamt[gi]),
      .stageValid(stValid[gi+1]),
      .stageData (stData[gi+1]),
      .stageOp   (stOp[gi+1]),
      .stageShamt(stShamt[gi+1])
    );

    assign fullVec[gi] = stValid[gi+1];
    // A stage may load when it or any later stage has a hole, or the consumer drains the pipe.
    // Flattened from the ready chain so only registered valids and out_ready feed it.
    assign loadEn[gi] = out_ready || !(&fullVec[SHAMT_W-1:gi]);
  end

  assign in_ready  = loadEn[0];
  assign out_valid = stValid[SHAMT_W];
  assign dataOut   = stData[SHAMT_W];

  logic unusedBits;
  assign unusedBits = &{1'b0, dataB[WIDTH-1:SHAMT_W], stOp[SHAMT_W], stShamt[SHAMT_W]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: directed WIDTH=32 cases plus a randomized WIDTH=8 stream
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_shifter;
  import pipelined_shifter_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, do32;
  logic [1:0]  op32;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] a8, b8, do8;
  logic [1:0] op8;

  pipelined_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .dataA(a32), .dataB(b32),
    .op(op32), .out_valid(ov32), .out_ready(or32), .dataOut(do32)
  );

  pipelined_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .dataA(a8), .dataB(b8),
    .op(op8), .out_valid(ov8), .out_ready(or8), .dataOut(do8)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [63:0] q32[$];
  logic [63:0] q8[$];
  int          recv32, recv8;
  bit          stall32, stall8;
  logic [31:0] held32;
  logic [7:0]  held8;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Reference: shift amount is dataB mod width; results computed with plain 64-bit arithmetic.
  function automatic logic [63:0] refShift(input logic [1:0] o, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
    logic [63:0] mask;
    logic [63:0] x;
    logic [63:0] r;
    int          amt;
    mask = (64'd1 << w) - 64'd1;
    x    = a & mask;
    amt  = int'(b % 64'(w));
    case (o)
      OP_SLL: r = x << amt;
      OP_SRL: r = x >> amt;
      OP_SRA: r = x[w-1] ? ((x >> amt) | (mask & ~(mask >> amt))) : (x >> amt);
`ifdef SHIFTER_ROTATE_EN
      default: r = (x >> amt) | (x << (w - amt));
`else
      default: r = x >> amt;
`endif
    endcase
    return r & mask;
  endfunction

  // Called at posedge+1 with inputs already driven; samples at posedge+8, returns at next posedge+1.
  task automatic cycle32(output bit acc);
    logic [63:0] expv;
    #7;
    acc = iv32 && ir32;
    if (stall32) begin
      check("hold32_valid", 64'(ov32), 64'd1);
      check("hold32_data", 64'(do32), 64'(held32));
    end
    if (ov32 && or32) begin
      recv32++;
      if (q32.size() == 0) check("extra_out32", 64'(ov32), 64'd0);
      else begin
        expv = q32.pop_front();
        check("order32", 64'(do32), expv);
      end
    end
    if (acc) q32.push_back(refShift(op32, 64'(a32), 64'(b32), 32));
    stall32 = ov32 && !or32;
    held32  = do32;
    @(posedge clk); #1;
  endtask

  task automatic cycle8(output bit acc);
    logic [63:0] expv;
    #7;
    acc = iv8 && ir8;
    if (stall8) begin
      check("hold8_valid", 64'(ov8), 64'd1);
      check("hold8_data", 64'(do8), 64'(held8));
    end
    if (ov8 && or8) begin
      recv8++;
      if (q8.size() == 0) check("extra_out8", 64'(ov8), 64'd0);
      else begin
        expv = q8.pop_front();
        check("order8", 64'(do8), expv);
      end
    end
    if (acc) q8.push_back(refShift(op8, 64'(a8), 64'(b8), 8));
    stall8 = ov8 && !or8;
    held8  = do8;
    @(posedge clk); #1;
  endtask

  task automatic single32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag);
    int n;
    op32 = o; a32 = a; b32 = b; iv32 = 1'b1; or32 = 1'b1;
    check({tag, "_inrdy"}, 64'(ir32), 64'd1);
    @(posedge clk); #1;
    iv32 = 1'b0;
    n = 1;
    while (!ov32 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd5);
    check({tag, "_data"}, 64'(do32), 64'(expv));
    @(posedge clk); #1;
  endtask

  task automatic single8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input string tag);
    int n;
    op8 = o; a8 = a; b8 = b; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd3);
    check({tag, "_data"}, 64'(do8), refShift(o, 64'(a), 64'(b), 8));
    @(posedge clk); #1;
  endtask

  logic [31:0] ba [8];
  logic [31:0] bb [8];
  logic [1:0]  bo [8];

  initial begin
    bit acc;
    int sent;
    int n;
    int sent8;

    rst = 1'b1;
    iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; op32 = '0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;
    stall32 = 1'b0; stall8 = 1'b0; recv32 = 0; recv8 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov32", 64'(ov32), 64'd0);
    check("rst_do32", 64'(do32), 64'd0);
    check("rst_ov8", 64'(ov8), 64'd0);
    check("rst_do8", 64'(do8), 64'd0);
    rst = 1'b0;
    check("rst_ir32", 64'(ir32), 64'd1);
    check("rst_ir8", 64'(ir8), 64'd1);

    // Directed WIDTH=32 cases
    single32(OP_SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, "sll31");
    single32(OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra4");
    single32(OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl4");
    single32(OP_SRA, 32'h7000_000F, 32'd35, 32'h0E00_0001, "sra_pos");
`ifdef SHIFTER_ROTATE_EN
    single32(OP_ROR, 32'h0000_0001, 32'h21, 32'h8000_0000, "ror1");
`else
    single32(OP_ROR, 32'h0000_0001, 32'h21, 32'h0000_0000, "ror1");
`endif
    for (int o = 0; o < 4; o++) begin
      single32(2'(o), 32'hA5C3_1234, 32'h60, 32'hA5C3_1234, $sformatf("zero_amt_op%0d", o));
    end

    // Back-to-back with a 10-cycle consumer stall
    for (int i = 0; i < 8; i++) begin
      ba[i] = $urandom; bb[i] = $urandom; bo[i] = 2'($urandom);
    end
    sent = 0; recv32 = 0; or32 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      iv32 = (sent < 8);
      if (sent < 8) begin a32 = ba[sent]; b32 = bb[sent]; op32 = bo[sent]; end
      check($sformatf("b2b_inrdy_c%0d", c), 64'(ir32), (c < 5) ? 64'd1 : 64'd0);
      cycle32(acc);
      if (acc) sent++;
    end
    or32 = 1'b1;
    n = 0;
    while ((sent < 8 || q32.size() != 0) && n < 40) begin
      iv32 = (sent < 8);
      if (sent < 8) begin a32 = ba[sent]; b32 = bb[sent]; op32 = bo[sent]; end
      cycle32(acc);
      if (acc) sent++;
      n++;
    end
    iv32 = 1'b0;
    check("b2b_recv", 64'(recv32), 64'd8);
    check("b2b_left", 64'(q32.size()), 64'd0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      iv32 = 1'b1; a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
      cycle32(acc);
    end
    iv32 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q32.delete();
    stall32 = 1'b0;
    recv32 = 0;
    check("midrst_ov32", 64'(ov32), 64'd0);
    check("midrst_do32", 64'(do32), 64'd0);
    check("midrst_ir32", 64'(ir32), 64'd1);
    for (int i = 0; i < 12; i++) cycle32(acc);
    check("midrst_stale", 64'(recv32), 64'd0);

    // WIDTH=8: latency on isolated ops, then a randomized stream with random stalls
    for (int i = 0; i < 6; i++) begin
      single8(2'($urandom), 8'($urandom), 8'($urandom), $sformatf("w8_single%0d", i));
    end
    sent8 = 0; recv8 = 0;
    for (int c = 0; c < 300; c++) begin
      iv8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
      or8 = ($urandom_range(0, 3) != 0);
      cycle8(acc);
      if (acc) sent8++;
    end
    iv8 = 1'b0; or8 = 1'b1;
    n = 0;
    while (q8.size() != 0 && n < 20) begin
      cycle8(acc);
      n++;
    end
    check("rnd8_left", 64'(q8.size()), 64'd0);
    check("rnd8_count", 64'(recv8), 64'(sent8));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
